// File: rtl/stark_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stark_pkg : shared pipeline types and constants for the Stark core       |
// | Rev 1.1   : extract-stage group entry type and NOP instruction word      |
// +--------------------------------------------------------------------------+
package stark_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  bno_t;
    logic [4:0]  bno_f;
  } pc_address_ex_t;

  localparam logic [31:0] RSTPC  = 32'hFFFC_0100;
  localparam logic [5:0]  OP_NOP = 6'h0B;

  // One NOP instruction word; an empty group is five of these.
  localparam logic [31:0] EXT_NOP_INS = {4{2'd3, OP_NOP}};

  typedef struct packed {
    logic [4:0][31:0] ins;
    pc_address_ex_t   pc;
    logic [5:0]       irq;
    logic             irqf;
    logic [31:0]      carry_mod;
    logic             v;
  } ext_grp_t;

endpackage
`default_nettype wire

// File: rtl/stark_ext_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stark_ext_align : slices a five-instruction group out of a line pair     |
// | Rev 1.0         : initial release                                        |
// +--------------------------------------------------------------------------+
module stark_ext_align (
  input  logic [1023:0]    line,
  input  logic [3:0]       pc_word,
  output logic [4:0][31:0] ins
);

  // Bit offset of the group start; the last word ends at byte 79 at most.
  logic [9:0] w_base;
  assign w_base = {1'b0, pc_word, 5'b0};

  for (genvar i = 0; i < 5; i++) begin : g_ins
    assign ins[i] = line[w_base + 10'(32 * i) +: 32];
  end

endmodule
`default_nettype wire

// File: rtl/stark_pipeline_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stark_pipeline_ext : extract stage, group queue between fetch and decode |
// | Rev 1.0            : initial release                                     |
// +--------------------------------------------------------------------------+
module stark_pipeline_ext
  import stark_pkg::*;
#(
  parameter int QDEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fet_v,
  input  logic [1023:0]    ic_line_fet,
  input  pc_address_ex_t   pc0_fet,
  input  logic [5:0]       irq_fet,
  input  logic             irqf_fet,
  input  logic [31:0]      carry_mod_fet,
  input  logic             stomp_ext,
  input  logic [4:0]       stomp_bno,
  input  logic             dec_rdy,
  output logic             fet_en,
  output logic [4:0][31:0] ins_ext,
  output pc_address_ex_t   pc_ext,
  output logic [5:0]       irq_ext,
  output logic             irqf_ext,
  output logic [31:0]      carry_mod_ext,
  output logic             grp_v_ext,
  output logic             ovf
);

  localparam int PTR_W = $clog2(QDEP);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL      = CNT_W'(QDEP);
  localparam logic [CNT_W-1:0] C_FETCH_MAX = CNT_W'(QDEP - 2);

  localparam pc_address_ex_t C_RST_PC = '{pc: RSTPC, bno_t: 5'd1, bno_f: 5'd1};
  localparam ext_grp_t C_RST_GRP = '{
    ins: {5{EXT_NOP_INS}}, pc: C_RST_PC, irq: 6'd0, irqf: 1'b0,
    carry_mod: 32'd0, v: 1'b0
  };

  ext_grp_t         r_q [QDEP];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  pc_address_ex_t   r_hold_pc;
  logic [5:0]       r_hold_irq;
  logic             r_hold_irqf;
  logic [31:0]      r_hold_carry_mod;

  logic [4:0][31:0] w_ins;
  ext_grp_t         w_head;
  ext_grp_t         w_new;
  logic             w_empty;
  logic             w_full;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;

  stark_ext_align u_align (
    .line    (ic_line_fet),
    .pc_word (pc0_fet.pc[5:2]),
    .ins     (w_ins)
  );

  assign w_head     = r_q[r_rd];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == C_FULL);
  assign w_push_req = fet_v && !(stomp_ext && (pc0_fet.bno_t != stomp_bno));
  // Dead heads drain one per cycle without waiting for decode.
  assign w_pop      = !w_empty && (!w_head.v || dec_rdy);
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign w_new = '{
    ins: w_ins, pc: pc0_fet, irq: irq_fet, irqf: irqf_fet,
    carry_mod: carry_mod_fet, v: 1'b1
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEP; i++) begin
        r_q[i] <= C_RST_GRP;
      end
      r_rd             <= '0;
      r_wr             <= '0;
      r_count          <= '0;
      r_ovf            <= 1'b0;
      r_hold_pc        <= C_RST_PC;
      r_hold_irq       <= 6'd0;
      r_hold_irqf      <= 1'b0;
      r_hold_carry_mod <= 32'd0;
    end else begin
      for (int i = 0; i < QDEP; i++) begin
        if (w_push && (r_wr == PTR_W'(i))) begin
          r_q[i] <= w_new;
        end else if (stomp_ext && (r_q[i].pc.bno_t != stomp_bno)) begin
          r_q[i].v <= 1'b0;
        end
      end
      // Remember the last head shown so an empty queue keeps its side data.
      if (!w_empty) begin
        r_hold_pc        <= w_head.pc;
        r_hold_irq       <= w_head.irq;
        r_hold_irqf      <= w_head.irqf;
        r_hold_carry_mod <= w_head.carry_mod;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push_req && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    ins_ext       = {5{EXT_NOP_INS}};
    pc_ext        = r_hold_pc;
    irq_ext       = r_hold_irq;
    irqf_ext      = r_hold_irqf;
    carry_mod_ext = r_hold_carry_mod;
    grp_v_ext     = 1'b0;
    if (!w_empty) begin
      ins_ext       = w_head.ins;
      pc_ext        = w_head.pc;
      irq_ext       = w_head.irq;
      irqf_ext      = w_head.irqf;
      carry_mod_ext = w_head.carry_mod;
      grp_v_ext     = w_head.v;
    end
  end

  assign fet_en = (r_count <= C_FETCH_MAX);
  assign ovf    = r_ovf;

endmodule
`default_nettype wire
